// File: rtl/fetch_mem_if.sv
// Fetch-side memory interface: credit-tracked request issue, in-order response FIFO, flush drain.
// Optional FETCH_MEM_IF_BYPASS_EN: an empty FIFO lets a response reach fetch in the same cycle.
module fetch_mem_if #(
    parameter int P_RESP_DEPTH = 4,
    parameter int P_CNT_W      = 3
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFLUSH,
    input  logic        iFETCH_REQ,
    output logic        oFETCH_LOCK,
    input  logic [1:0]  iFETCH_MMUMOD,
    input  logic [31:0] iFETCH_ADDR,
    output logic        oINST_VALID,
    output logic        oINST_PAGEFAULT,
    output logic [13:0] oINST_MMU_FLAGS,
    output logic [31:0] oINST,
    input  logic        iINST_LOCK,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic        iMEM_PAGEFAULT,
    input  logic [13:0] iMEM_MMU_FLAGS,
    input  logic [31:0] iMEM_DATA
);
    localparam int PTR_W = (P_RESP_DEPTH > 1) ? $clog2(P_RESP_DEPTH) : 1;
    localparam int ENT_W = 1 + 14 + 32;
    localparam logic [P_CNT_W:0]   DEPTH_C = (P_CNT_W+1)'(P_RESP_DEPTH);
    localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             stateQ, stateD;
    logic [P_CNT_W-1:0] outstandingQ, outstandingD;
    logic [P_CNT_W-1:0] discardQ, discardD;
    logic [P_CNT_W-1:0] fifoCount;
    logic [P_CNT_W-1:0] owedAfterResp;
    logic [P_CNT_W:0]   credits;
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [ENT_W-1:0]   fifoMem [P_RESP_DEPTH];
    logic [ENT_W-1:0]   headEntry, outEntry;
    logic               fifoEmpty, fifoWr, fifoRd, fifoClr, bypass, issue;

    always_comb begin
        credits       = {1'b0, outstandingQ} + {1'b0, fifoCount};
        oFETCH_LOCK   = iMEM_LOCK || (credits >= DEPTH_C) || (stateQ == DRAIN);
        issue         = iFETCH_REQ && !oFETCH_LOCK && !iFLUSH;
        owedAfterResp = outstandingQ - P_CNT_W'(iMEM_VALID);
        fifoEmpty     = (fifoCount == '0);
`ifdef FETCH_MEM_IF_BYPASS_EN
        bypass = fifoEmpty && (stateQ == RUN) && iMEM_VALID && !iINST_LOCK && !iFLUSH;
`else
        bypass = 1'b0;
`endif
        fifoRd    = !fifoEmpty && !iINST_LOCK && !iFLUSH;
        // A bypassed response is consumed directly and never occupies a FIFO slot.
        fifoWr    = (stateQ == RUN) && iMEM_VALID && !iFLUSH && !bypass;
        headEntry = fifoEmpty ? '0 : fifoMem[rdPtr];
        outEntry  = bypass ? {iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA} : headEntry;
    end

    assign oMEM_REQ        = issue;
    assign oMEM_ADDR       = iFETCH_ADDR;
    assign oMEM_MMUMOD     = iFETCH_MMUMOD;
    assign oINST_VALID     = fifoRd || bypass;
    assign oINST_PAGEFAULT = outEntry[ENT_W-1];
    assign oINST_MMU_FLAGS = outEntry[45:32];
    assign oINST           = outEntry[31:0];

    always_comb begin
        stateD       = stateQ;
        outstandingD = outstandingQ;
        discardD     = discardQ;
        fifoClr      = 1'b0;
        case (stateQ)
            RUN: begin
                if (iFLUSH) begin
                    fifoClr      = 1'b1;
                    outstandingD = '0;
                    // A response arriving with the flush is already accounted for.
                    if (owedAfterResp != '0) begin
                        stateD   = DRAIN;
                        discardD = owedAfterResp;
                    end
                end else begin
                    outstandingD = outstandingQ + P_CNT_W'(issue) - P_CNT_W'(iMEM_VALID);
                end
            end
            DRAIN: begin
                fifoClr = iFLUSH;
                if (iMEM_VALID) begin
                    discardD = discardQ - CNT_ONE;
                    if (discardQ == CNT_ONE) stateD = RUN;
                end
            end
            default: stateD = RUN;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            stateQ       <= RUN;
            outstandingQ <= '0;
            discardQ     <= '0;
        end else begin
            stateQ       <= stateD;
            outstandingQ <= outstandingD;
            discardQ     <= discardD;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else if (fifoClr) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (fifoWr) wrPtr <= wrPtr + PTR_W'(1);
            if (fifoRd) rdPtr <= rdPtr + PTR_W'(1);
            fifoCount <= fifoCount + P_CNT_W'(fifoWr) - P_CNT_W'(fifoRd);
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (fifoWr) fifoMem[wrPtr] <= {iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA};
    end

    unexpectedResp: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        !((stateQ == RUN) && iMEM_VALID && (outstandingQ == '0)));

    fifoOverflow: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        !(fifoWr && !fifoRd && !fifoClr && (fifoCount == P_CNT_W'(P_RESP_DEPTH))));
endmodule
